// File: rtl/cook_timer_if.sv
// rtl/cook_timer_if.sv - cook_timer user-panel bundle: switch/button inputs, BCD digits and status outputs
interface cook_timer_if;
  logic [3:0] in;
  logic       pushButton;
  logic       onOff;
  logic [3:0] secOnes;
  logic [3:0] secTens;
  logic [3:0] minOnes;
  logic [3:0] minTens;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output in, pushButton, onOff,
    input  secOnes, secTens, minOnes, minTens, running, done, alarm
  );

  modport slave (
    input  in, pushButton, onOff,
    output secOnes, secTens, minOnes, minTens, running, done, alarm
  );
endinterface

// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - BCD mm:ss kitchen countdown timer with digit entry, pause and done alarm
// Optional COOK_TIMER_BEEP_EN: alarm beeps (toggles every TICK_DIV/4 cycles) in DONE instead of steady high.
module cook_timer #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  cook_timer_if.slave  bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, ENTRY, RUN, PAUSE, DONE} state_t;

  state_t        state_q;
  logic [3:0]    sec1_q, sec10_q, min1_q, min10_q;
  logic [PW-1:0] presc_q;
  logic          running_q, done_q;
  logic [2:0]    pb_sync_q, on_sync_q;

  logic [3:0]    sec1_d, sec10_d, min1_d, min10_d;
  logic          press, on_lvl, on_rise, tick, dec_zero, any_nz, enter_done;

  // Stage [1] is the synchronized level; stage [2] is its previous value for edge detection.
  assign press   = pb_sync_q[1] & ~pb_sync_q[2];
  assign on_lvl  = on_sync_q[1];
  assign on_rise = on_sync_q[1] & ~on_sync_q[2];
  assign tick    = (state_q == RUN) && (presc_q == TICK_MAX);
  assign any_nz  = (sec1_q != 4'd0) || (sec10_q != 4'd0) || (min1_q != 4'd0) || (min10_q != 4'd0);

  // One-second decrement with mm:ss borrows; an entered secTens above 5 just counts down literally.
  always_comb begin
    sec1_d  = sec1_q - 4'd1;
    sec10_d = sec10_q;
    min1_d  = min1_q;
    min10_d = min10_q;
    if (sec1_q == 4'd0) begin
      sec1_d = 4'd9;
      if (sec10_q == 4'd0) begin
        sec10_d = 4'd5;
        if (min1_q == 4'd0) begin
          min1_d  = 4'd9;
          min10_d = min10_q - 4'd1;
        end else begin
          min1_d = min1_q - 4'd1;
        end
      end else begin
        sec10_d = sec10_q - 4'd1;
      end
    end
  end

  assign dec_zero   = (sec1_d == 4'd0) && (sec10_d == 4'd0) && (min1_d == 4'd0) && (min10_d == 4'd0);
  assign enter_done = tick && dec_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sec1_q    <= 4'd0;
      sec10_q   <= 4'd0;
      min1_q    <= 4'd0;
      min10_q   <= 4'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      pb_sync_q <= 3'b000;
      on_sync_q <= 3'b000;
    end else begin
      pb_sync_q <= {pb_sync_q[1:0], bus.pushButton};
      on_sync_q <= {on_sync_q[1:0], bus.onOff};
      case (state_q)
        IDLE, ENTRY: begin
          if (press) begin
            if (bus.in <= 4'd9) begin
              min10_q <= min1_q;
              min1_q  <= sec10_q;
              sec10_q <= sec1_q;
              sec1_q  <= bus.in;
              state_q <= ENTRY;
            end
          end else if (state_q == ENTRY && on_rise && any_nz) begin
            state_q   <= RUN;
            presc_q   <= '0;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          // Prescaler advances on the exit edge too, so a pause captures the count reached.
          presc_q <= tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            sec1_q  <= sec1_d;
            sec10_q <= sec10_d;
            min1_q  <= min1_d;
            min10_q <= min10_d;
          end
          if (enter_done) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (!on_lvl) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (press) begin
            sec1_q  <= 4'd0;
            sec10_q <= 4'd0;
            min1_q  <= 4'd0;
            min10_q <= 4'd0;
            state_q <= IDLE;
          end else if (on_rise) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        DONE: begin
          if (!on_lvl) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef COOK_TIMER_BEEP_EN
  localparam int unsigned BEEP_HALF = TICK_DIV / 4;
  localparam int unsigned BW = $clog2(BEEP_HALF + 1);
  localparam logic [BW-1:0] BEEP_MAX = BW'(BEEP_HALF - 1);

  logic [BW-1:0] beep_cnt_q;
  logic          alarm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beep_cnt_q <= '0;
      alarm_q    <= 1'b0;
    end else if (enter_done) begin
      beep_cnt_q <= '0;
      alarm_q    <= 1'b1;
    end else if (state_q == DONE && on_lvl) begin
      if (beep_cnt_q == BEEP_MAX) begin
        beep_cnt_q <= '0;
        alarm_q    <= ~alarm_q;
      end else begin
        beep_cnt_q <= beep_cnt_q + 1'b1;
      end
    end else begin
      beep_cnt_q <= '0;
      alarm_q    <= 1'b0;
    end
  end

  assign bus.alarm = alarm_q;
`else
  assign bus.alarm = done_q;
`endif

  assign bus.secOnes = sec1_q;
  assign bus.secTens = sec10_q;
  assign bus.minOnes = min1_q;
  assign bus.minTens = min10_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_cook_timer.sv
// tb/tb_cook_timer.sv - directed self-checking bench for cook_timer with TICK_DIV=10
module tb_cook_timer;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n;

  cook_timer_if bus ();

  cook_timer #(.TICK_DIV(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {bus.minTens, bus.minOnes, bus.secTens, bus.secOnes};
  endfunction

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.onOff = 1'b0;
    bus.pushButton = 1'b0;
    bus.in = 4'd0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic press(input logic [3:0] d);
    bus.in = d;
    bus.pushButton = 1'b1;
    cyc(4);
    bus.pushButton = 1'b0;
    cyc(4);
  endtask

  task automatic start(input string tag);
    int k;
    bus.onOff = 1'b1;
    k = 0;
    while (!bus.running && k < 20) begin
      cyc(1);
      k++;
    end
    check(tag, bus.running, 1);
  endtask

  task automatic count_to_done(output int k, input int limit);
    k = 0;
    while (!bus.done && k < limit) begin
      cyc(1);
      k++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in = 4'd0;
    bus.pushButton = 1'b0;
    bus.onOff = 1'b0;
    cyc(2);
    check("rst_digits", digits(), 16'h0000);
    check("rst_running", bus.running, 0);
    check("rst_done", bus.done, 0);
    check("rst_alarm", bus.alarm, 0);
    reset = 1'b0;
    cyc(1);

    // Entry shifting and invalid digit rejection
    press(4'd1); press(4'd2); press(4'd3); press(4'd0);
    check("entry_1230", digits(), 16'h1230);
    check("entry_not_running", bus.running, 0);
    press(4'd12);
    check("entry_invalid", digits(), 16'h1230);

    // 0:03 countdown to DONE
    do_reset();
    press(4'd3);
    check("entry_0003", digits(), 16'h0003);
    start("start_0003");
    cyc(9);
    check("tick1_not_yet", bus.secOnes, 3);
    cyc(1);
    check("tick1", bus.secOnes, 2);
    cyc(10);
    check("tick2", bus.secOnes, 1);
    cyc(10);
    check("tick3_digits", digits(), 16'h0000);
    check("tick3_done", bus.done, 1);
    check("tick3_running", bus.running, 0);
`ifdef COOK_TIMER_BEEP_EN
    for (int i = 0; i < 8; i++) begin
      check("beep_pattern", bus.alarm, ((i / 2) % 2 == 0) ? 1 : 0);
      cyc(1);
    end
`else
    check("alarm_at_done", bus.alarm, 1);
    cyc(7);
    check("alarm_steady", bus.alarm, 1);
`endif
    check("done_holds", digits(), 16'h0000);
    bus.onOff = 1'b0;
    cyc(4);
    check("done_exit_done", bus.done, 0);
    check("done_exit_alarm", bus.alarm, 0);
    check("done_exit_running", bus.running, 0);

    // Minute borrow 1:00 -> 0:59
    do_reset();
    press(4'd1); press(4'd0); press(4'd0);
    start("start_0100");
    cyc(10);
    check("borrow_0059", digits(), 16'h0059);

    // 0:90 counts literal seconds
    do_reset();
    press(4'd9); press(4'd0);
    start("start_0090");
    count_to_done(n, 2000);
    check("ticks_0090", n, 900);

    // Pause 4 cycles past a tick, resume continues the prescaler
    do_reset();
    press(4'd5);
    start("start_0005");
    cyc(10);
    check("pause_pre_tick", bus.secOnes, 4);
    cyc(1);
    bus.onOff = 1'b0;
    cyc(50);
    check("paused_running", bus.running, 0);
    check("paused_digits", digits(), 16'h0004);
    start("resume");
    n = 0;
    while (bus.secOnes == 4'd4 && n < 20) begin
      cyc(1);
      n++;
    end
    check("resume_gap", n, 6);
    bus.onOff = 1'b0;
    cyc(4);
    check("pause2_running", bus.running, 0);
    press(4'd7);
    check("pause_clear", digits(), 16'h0000);
    press(4'd7);
    check("idle_after_clear", digits(), 16'h0007);

    // Asynchronous reset mid-run; onOff held high afterwards must not start
    do_reset();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    start("start_1234");
    cyc(3);
    check("pre_reset_digits", digits(), 16'h1234);
    #2 reset = 1'b1;
    #1;
    check("async_rst_digits", digits(), 16'h0000);
    check("async_rst_running", bus.running, 0);
    check("async_rst_done", bus.done, 0);
    check("async_rst_alarm", bus.alarm, 0);
    cyc(1);
    reset = 1'b0;
    cyc(30);
    check("no_run_after_rst", bus.running, 0);
    press(4'd5);
    cyc(20);
    check("no_run_held_on", bus.running, 0);
    check("held_on_digits", digits(), 16'h0005);

    // All-zero entry does not start
    do_reset();
    press(4'd0);
    bus.onOff = 1'b1;
    cyc(15);
    check("zero_no_start", bus.running, 0);

    // Maximum entry 99:99
    do_reset();
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    check("entry_9999", digits(), 16'h9999);
    start("start_9999");
    count_to_done(n, 70000);
    check("ticks_9999", n, 60390);
    check("final_9999", digits(), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
